// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and default sizes for the multi-port register file
// Clear-engine state encoding plus default width/index constants.
package reg_file_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_AUX_REG = 19;
  localparam int DEF_OBS_REG = 7;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clrState_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - register file access bus (write ports, read ports, clear control, observation)
// The slave modport is the register file; the master modport is the datapath driving it.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              we_a;
  logic [ADDR_W-1:0] waddr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              we_b;
  logic [DATA_W-1:0] wdata_b;
  logic [ADDR_W-1:0] raddr_0;
  logic [ADDR_W-1:0] raddr_1;
  logic [DATA_W-1:0] rdata_0;
  logic [DATA_W-1:0] rdata_1;
  logic              clr_req;
  logic              clr_busy;
  logic              wr_drop;
  logic [DATA_W-1:0] obs_data;

  modport slave (
    input  we_a, waddr_a, wdata_a, we_b, wdata_b, raddr_0, raddr_1, clr_req,
    output rdata_0, rdata_1, clr_busy, wr_drop, obs_data
  );

  modport master (
    output we_a, waddr_a, wdata_a, we_b, wdata_b, raddr_0, raddr_1, clr_req,
    input  rdata_0, rdata_1, clr_busy, wr_drop, obs_data
  );

endinterface

// File: rtl/reg_file_clr_fsm.sv
// rtl/reg_file_clr_fsm.sv - sequential bulk-clear engine for the register file
// Walks every index once after clr_req; flags writes that arrive during the walk.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic              weAny,
  output logic              clrBusy,
  output logic              wrDrop,
  output logic              clrEn,
  output logic [ADDR_W-1:0] clrIdx
);

  clrState_e         state, nextState;
  logic [ADDR_W-1:0] idx, nextIdx;
  logic              nextDrop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= CLR_IDLE;
      idx    <= '0;
      wrDrop <= 1'b0;
    end else begin
      state  <= nextState;
      idx    <= nextIdx;
      wrDrop <= nextDrop;
    end
  end

  always_comb begin
    nextState = state;
    nextIdx   = idx;
    nextDrop  = 1'b0;
    clrEn     = 1'b0;
    case (state)
      CLR_IDLE: begin
        nextIdx = '0;
        if (clr_req) nextState = CLR_RUN;
      end
      CLR_RUN: begin
        clrEn    = 1'b1;
        nextDrop = weAny;
        // clr_req is deliberately not looked at here so the walk cannot restart
        if (idx == {ADDR_W{1'b1}}) begin
          nextState = CLR_IDLE;
          nextIdx   = '0;
        end else begin
          nextIdx = idx + ADDR_W'(1);
        end
      end
      default: begin
        nextState = CLR_IDLE;
        nextIdx   = '0;
      end
    endcase
  end

  assign clrBusy = (state == CLR_RUN);
  assign clrIdx  = idx;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file: two read ports, general and fixed-target write ports
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int AUX_REG = DEF_AUX_REG,
  parameter int OBS_REG = DEF_OBS_REG,
  parameter int ZERO_R0 = 0
) (
  input logic           clk,
  input logic           reset,
  reg_file_mp_if.slave  bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] AUX_ADDR = ADDR_W'(AUX_REG);
  localparam logic [ADDR_W-1:0] OBS_ADDR = ADDR_W'(OBS_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clrBusy, wrDrop, clrEn;
  logic [ADDR_W-1:0] clrIdx;
  logic              wrA, wrB;
  logic [DATA_W-1:0] rd0, rd1;

  reg_file_clr_fsm #(.ADDR_W(ADDR_W)) clrFsm (
    .clk     (clk),
    .reset   (reset),
    .clr_req (bus.clr_req),
    .weAny   (bus.we_a | bus.we_b),
    .clrBusy (clrBusy),
    .wrDrop  (wrDrop),
    .clrEn   (clrEn),
    .clrIdx  (clrIdx)
  );

  // Writes to a hard-wired zero register vanish silently, without a drop pulse.
  assign wrA = bus.we_a && !clrBusy && !(ZERO_R0 != 0 && bus.waddr_a == '0);
  assign wrB = bus.we_b && !clrBusy && !(ZERO_R0 != 0 && AUX_ADDR == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clrEn) begin
      mem[clrIdx] <= '0;
    end else begin
      if (wrA) mem[bus.waddr_a] <= bus.wdata_a;
      if (wrB) mem[AUX_ADDR]    <= bus.wdata_b;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = mem[addr];
`ifdef REGFILE_BYPASS_EN
    if (!clrBusy) begin
      if (wrA && bus.waddr_a == addr) v = bus.wdata_a;
      if (wrB && AUX_ADDR == addr)    v = bus.wdata_b;
    end
`endif
    if (ZERO_R0 != 0 && addr == '0) v = '0;
    return v;
  endfunction

  always_comb begin
    rd0 = readPort(bus.raddr_0);
    rd1 = readPort(bus.raddr_1);
  end

  assign bus.rdata_0  = rd0;
  assign bus.rdata_1  = rd1;
  assign bus.clr_busy = clrBusy;
  assign bus.wr_drop  = wrDrop;
  assign bus.obs_data = mem[OBS_ADDR];

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed and randomized checks of reg_file_mp against an array model
// Honours REGFILE_BYPASS_EN for same-cycle read expectations.
module tb_reg_file_mp;

  localparam int DW = 32, AW = 5, DEPTH = 32, AUX = 19, OBS = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW)) zbus ();

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .AUX_REG(AUX), .OBS_REG(OBS), .ZERO_R0(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .AUX_REG(AUX), .OBS_REG(OBS), .ZERO_R0(1)) dutZ (
    .clk(clk), .reset(reset), .bus(zbus)
  );

  logic [31:0] refMem [DEPTH];
  int          clrLeft;
  logic        refDrop;
  int          passCount = 0, failCount = 0, checkCount = 0;
  int          cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    logic [31:0] v;
    v = refMem[a];
`ifdef REGFILE_BYPASS_EN
    if (clrLeft == 0) begin
      if (bus.we_a && bus.waddr_a == a) v = bus.wdata_a;
      if (bus.we_b && a == 5'(AUX))     v = bus.wdata_b;
    end
`endif
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    clrLeft = 0;
    refDrop = 1'b0;
  endtask

  // One rising edge of the spec's behaviour, computed from the inputs held before it.
  task automatic modelEdge();
    if (clrLeft > 0) begin
      refMem[DEPTH - clrLeft] = '0;
      refDrop = bus.we_a || bus.we_b;
      clrLeft--;
    end else begin
      refDrop = 1'b0;
      if (bus.we_a) refMem[bus.waddr_a] = bus.wdata_a;
      if (bus.we_b) refMem[AUX] = bus.wdata_b;
      if (bus.clr_req) clrLeft = DEPTH;
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    bus.we_a = 1'b0; bus.we_b = 1'b0; bus.clr_req = 1'b0;
  endtask

  task automatic checkAll(input string tag);
    #1;
    chk({tag, ".rd0"},  bus.rdata_0, modelRead(bus.raddr_0));
    chk({tag, ".rd1"},  bus.rdata_1, modelRead(bus.raddr_1));
    chk({tag, ".busy"}, 32'(bus.clr_busy), 32'(clrLeft > 0));
    chk({tag, ".drop"}, 32'(bus.wr_drop), 32'(refDrop));
    chk({tag, ".obs"},  bus.obs_data, refMem[OBS]);
  endtask

  initial begin
    reset = 1'b1;
    setIdle();
    bus.waddr_a = '0; bus.wdata_a = '0; bus.wdata_b = '0;
    bus.raddr_0 = '0; bus.raddr_1 = '0;
    zbus.we_a = 1'b0; zbus.we_b = 1'b0; zbus.clr_req = 1'b0;
    zbus.waddr_a = '0; zbus.wdata_a = '0; zbus.wdata_b = '0;
    zbus.raddr_0 = '0; zbus.raddr_1 = '0;
    modelReset();

    @(negedge clk); @(negedge clk);
    chk("rst.busy", 32'(bus.clr_busy), 32'd0);
    chk("rst.drop", 32'(bus.wr_drop), 32'd0);
    chk("rst.obs",  bus.obs_data, 32'd0);
    chk("rst.rd0",  bus.rdata_0, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic port A write and observation tap
    bus.we_a = 1'b1; bus.waddr_a = 5'd5; bus.wdata_a = 32'hDEADBEEF;
    tick(); setIdle(); bus.raddr_0 = 5'd5;
    #1 chk("w5.rd0", bus.rdata_0, 32'hDEADBEEF);
    bus.we_a = 1'b1; bus.waddr_a = 5'd7; bus.wdata_a = 32'h1234;
    tick(); setIdle();
    #1 chk("w7.obs", bus.obs_data, 32'h1234);

    // Port collisions
    bus.we_a = 1'b1; bus.waddr_a = 5'd19; bus.wdata_a = 32'h1111;
    bus.we_b = 1'b1; bus.wdata_b = 32'h2222;
    tick(); setIdle(); bus.raddr_0 = 5'd19;
    #1 chk("coll.r19", bus.rdata_0, 32'h2222);
    bus.we_a = 1'b1; bus.waddr_a = 5'd3; bus.wdata_a = 32'hA;
    bus.we_b = 1'b1; bus.wdata_b = 32'hB;
    tick(); setIdle(); bus.raddr_0 = 5'd3; bus.raddr_1 = 5'd19;
    #1 chk("split.r3", bus.rdata_0, 32'hA);
    chk("split.r19", bus.rdata_1, 32'hB);

    // Same-cycle read of the register being written
    bus.we_a = 1'b1; bus.waddr_a = 5'd9; bus.wdata_a = 32'h55; bus.raddr_1 = 5'd9;
`ifdef REGFILE_BYPASS_EN
    #1 chk("byp.pre", bus.rdata_1, 32'h55);
`else
    #1 chk("byp.pre", bus.rdata_1, 32'h0);
`endif
    tick(); setIdle();
    #1 chk("byp.post", bus.rdata_1, 32'h55);

    // Fill, then bulk clear with a dropped write and a redundant clear request
    for (int i = 0; i < DEPTH; i++) begin
      bus.we_a = 1'b1; bus.waddr_a = 5'(i); bus.wdata_a = 32'(i + 1);
      tick();
    end
    setIdle();
    bus.clr_req = 1'b1;
    tick(); setIdle();
    checkAll("clr0");
    cnt = 1;
    while (bus.clr_busy === 1'b1 && cnt < 100) begin
      setIdle();
      if (cnt == 5) begin bus.we_a = 1'b1; bus.waddr_a = 5'd2; bus.wdata_a = 32'hAA; end
      if (cnt == 8) bus.clr_req = 1'b1;
      bus.raddr_0 = 5'($urandom); bus.raddr_1 = 5'($urandom);
      tick();
      if (cnt == 5) chk("clr.droppulse", 32'(bus.wr_drop), 32'd1);
      checkAll("clr");
      if (bus.clr_busy === 1'b1) cnt++;
    end
    setIdle();
    chk("clr.busylen", 32'(cnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr_0 = 5'(i);
      #1 chk("clr.zero", bus.rdata_0, 32'd0);
    end

    // Async reset in the middle of a clear walk
    for (int i = 0; i < DEPTH; i++) begin
      bus.we_a = 1'b1; bus.waddr_a = 5'(i); bus.wdata_a = $urandom | 32'h1;
      tick();
    end
    setIdle(); bus.clr_req = 1'b1;
    tick(); setIdle();
    repeat (10) tick();
    reset = 1'b1;
    #1 chk("rstmid.busy", 32'(bus.clr_busy), 32'd0);
    modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      bus.raddr_0 = 5'(i);
      #1 chk("rstmid.zero", bus.rdata_0, 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    bus.we_a = 1'b1; bus.waddr_a = 5'd4; bus.wdata_a = 32'h77;
    tick(); setIdle(); bus.raddr_0 = 5'd4;
    #1 chk("rstmid.wr", bus.rdata_0, 32'h77);

    // Hard-wired zero register instance
    zbus.we_a = 1'b1; zbus.waddr_a = 5'd0; zbus.wdata_a = 32'hFFFF; zbus.raddr_0 = 5'd0;
    #1 chk("z.pre", zbus.rdata_0, 32'd0);
    tick(); zbus.we_a = 1'b0;
    #1 chk("z.rd0", zbus.rdata_0, 32'd0);
    chk("z.drop", 32'(zbus.wr_drop), 32'd0);
    zbus.we_a = 1'b1; zbus.waddr_a = 5'd1; zbus.wdata_a = 32'h1234; zbus.raddr_0 = 5'd1;
    tick(); zbus.we_a = 1'b0;
    #1 chk("z.r1", zbus.rdata_0, 32'h1234);

    // Randomized traffic including occasional clears
    repeat (300) begin
      bus.we_a    = 1'($urandom % 2);
      bus.waddr_a = 5'($urandom);
      bus.wdata_a = $urandom;
      bus.we_b    = ($urandom % 4) == 0;
      bus.wdata_b = $urandom;
      bus.clr_req = ($urandom % 50) == 0;
      bus.raddr_0 = ($urandom % 3 == 0) ? bus.waddr_a : 5'($urandom);
      bus.raddr_1 = ($urandom % 3 == 0) ? 5'(AUX) : 5'($urandom);
      checkAll("rnd.pre");
      tick();
      checkAll("rnd.post");
    end
    setIdle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the KGP-RISC datapath and the next-generation register bank. It has two combinational read ports, a general write port, and a dedicated auxiliary write port into a fixed register (the extended-result register). It also provides an observation tap and a sequential bulk-clear engine, so software and test can zero the file without asserting the global reset.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- AUX_REG, 19, index written by auxiliary port B
- OBS_REG, 7, index driven onto obs_data
- ZERO_R0, 0, 1 = register 0 reads as zero and ignores writes
- clk  in  1  clock, all writes on rising edge
- reset  in  1  reset, asynchronous, active-high
- we_a  in  1  write enable, port A
- waddr_a  in  ADDR_W  write address, port A
- wdata_a  in  DATA_W  write data, port A
- we_b  in  1  write enable, auxiliary port B (target fixed at AUX_REG)
- wdata_b  in  DATA_W  write data, port B
- raddr_0 / raddr_1  in  ADDR_W  read addresses
- rdata_0 / rdata_1  out  DATA_W  read data, combinational
- clr_req  in  1  single-cycle request to start bulk clear
- clr_busy  out  1  bulk clear in progress
- wr_drop  out  1  registered pulse: a write was discarded during clear
- obs_data  out  DATA_W  stored value of OBS_REG, combinational

## Operation
- **Reset:** all registers are 0. The clear FSM returns to IDLE with index 0. clr_busy=0, wr_drop=0, obs_data=0, and rdata follows the zeroed storage.
- **Reads:** rdata_n is the stored register at raddr_n. All addresses are in range by construction, so no X path exists.
- **Writes:** port A writes waddr_a when we_a=1. Port B writes AUX_REG when we_b=1.
- **Write collision:** if both ports target AUX_REG in the same cycle, port B wins. Different targets both commit.
- **ZERO_R0=1:** writes to index 0 are discarded and do not raise wr_drop. Reads of index 0 return 0.
- **Clear FSM states:**
  - IDLE to CLEAR when clr_req=1.
  - In CLEAR, register[idx] is set to 0 each cycle and idx increments.
  - After idx=DEPTH-1, the FSM goes CLEAR to IDLE and idx wraps to 0.
- **Writes during CLEAR:** writes on either port are discarded. wr_drop=1 the following cycle for each cycle in which any we_x=1.
- **clr_req during CLEAR:** ignored; it does not restart the walk.
- **Reads during CLEAR:** return the current, partially cleared contents.
- **Reset mid-clear:** the async reset aborts the walk immediately and all storage is 0.

## Timing
- Write latency is 1 edge; the new value is visible on rdata after the edge (see Configuration for same-cycle bypass).
- clr_busy rises on the edge that samples clr_req and stays high for exactly DEPTH cycles; the file is fully zero when it falls.
- Writes are accepted again on the first edge where clr_busy was 0 before the edge.
- wr_drop is a registered 1-cycle pulse per dropping cycle.
- obs_data is never bypassed; it shows committed storage only.

## Configuration
- Macro REGFILE_BYPASS_EN enables write-to-read forwarding.
- **Defined:** when a read address matches an enabled, non-dropped write in the same cycle, rdata returns that write data combinationally.
  - Port B takes priority over port A for AUX_REG.
  - ZERO_R0 still forces 0 on index 0.
  - No forwarding occurs while clr_busy=1.
- **Undefined:** rdata shows storage only, so new data appears one cycle later.

## Structure
- reg_file_pkg holds:
  - the clear state enum (CLR_IDLE, CLR_RUN)
  - default constants: DATA_W, ADDR_W, AUX_REG index, OBS_REG index
- One sub-module, reg_file_clr_fsm:
  - contains the state, walk index and clr_busy / wr_drop generation
  - outputs clr_en and clr_idx to the storage array
- The storage array, write arbitration and read muxes stay in reg_file_mp.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via port A, read r5 next cycle -> rdata_0=0xDEADBEEF; r7 write 0x1234 -> obs_data=0x1234 after edge.
- we_a to AUX_REG=19 with 0x1111 and we_b with 0x2222 in the same cycle -> r19=0x2222; we_a to r3=0xA plus we_b=0xB -> r3=0xA, r19=0xB.
- Fill all 32 registers with index+1, pulse clr_req -> clr_busy high for exactly 32 cycles. After it falls, every register reads 0. A write issued mid-clear is discarded, wr_drop=1 one cycle later, and a second clr_req mid-clear does not extend busy.
- Assert async reset at clear cycle 10 -> clr_busy=0 immediately and all registers read 0. A write on the next edge commits.
- With REGFILE_BYPASS_EN: write r9=0x55 with raddr_1=9 in the same cycle -> rdata_1=0x55 before the edge. Without it -> old value until after the edge.
- ZERO_R0=1: write r0=0xFFFF -> rdata_0 at raddr 0 is 0 and wr_drop stays 0.
